// File: rtl/ram256_arbiter_if.sv
// Requester-side bus of the 256-byte RAM arbiter: one instance per requester.
interface ram256_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/ram256_arbiter.sv
// Round-robin two-requester arbiter/sequencer for the four-bank 256-byte RAM.
// Each granted transaction runs IDLE -> ACCESS -> COMPLETE and acknowledges
// the owner in the cycle after COMPLETE.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a request; owner's ack is high in the first cycle
// ACCESS   | bank address/data driven, ram_we high for a write
// COMPLETE | ram_we low, address held so ram_dout settles for a read
module ram256_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int BANK_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  ram256_arbiter_if.slave          a,
  ram256_arbiter_if.slave          b,
  output logic [BANK_W-1:0]        ram_sel,
  output logic [ADDR_W-BANK_W-1:0] ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  output logic                     ram_we,
  input  logic [DATA_W-1:0]        ram_dout,
  output logic                     busy
);

  localparam int LOC_W = ADDR_W - BANK_W;

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            last;
  logic              lat_we;
  logic              a_ack_q;
  logic              b_ack_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic              a_live;
  logic              b_live;
  logic              grant;
  logic              grant_b;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // A requester being acked still holds req this cycle, so mask it out.
  assign a_live = a.req & ~a_ack_q;
  assign b_live = b.req & ~b_ack_q;

  // Arbitration: single requester wins outright, a tie goes to whoever was not served last.
  always_comb begin
    grant   = a_live | b_live;
    grant_b = b_live;
    if (a_live && b_live) begin
      grant_b = (last == OWN_A);
    end
  end

  // Winner's transaction fields, captured at the grant edge.
  always_comb begin
    win_we    = a.we;
    win_addr  = a.addr;
    win_wdata = a.wdata;
    if (grant_b) begin
      win_we    = b.we;
      win_addr  = b.addr;
      win_wdata = b.wdata;
    end
  end

  // Sequencer FSM with registered RAM-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_A;
      last      <= OWN_B;
      lat_we    <= 1'b0;
      ram_sel   <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      busy      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= grant_b ? OWN_B : OWN_A;
            lat_we   <= win_we;
            ram_sel  <= win_addr[ADDR_W-1:LOC_W];
            ram_addr <= win_addr[LOC_W-1:0];
            ram_din  <= win_wdata;
            ram_we   <= win_we;
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          state  <= COMPLETE;
        end
        COMPLETE: begin
          if (owner == OWN_A) begin
            a_ack_q <= 1'b1;
            if (!lat_we) begin
              a_rdata_q <= ram_dout;
            end
          end else begin
            b_ack_q <= 1'b1;
            if (!lat_we) begin
              b_rdata_q <= ram_dout;
            end
          end
          last  <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign a.ack   = a_ack_q;
  assign a.rdata = a_rdata_q;
  assign b.ack   = b_ack_q;
  assign b.rdata = b_rdata_q;

endmodule

// File: tb/tb_ram256_arbiter.sv
// Directed bench for ram256_arbiter with a four-bank synchronous RAM model.
module tb_ram256_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ram_sel;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout = 8'h00;
  logic       busy;

  logic [7:0] mem [256] = '{default: 8'h00};

  int vectors = 0;
  int miscompares = 0;

  ram256_arbiter_if #(.ADDR_W(8), .DATA_W(8)) a_if ();
  ram256_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b_if ();

  ram256_arbiter #(.DATA_W(8), .ADDR_W(8), .BANK_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a_if),
    .b        (b_if),
    .ram_sel  (ram_sel),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Bank array behind the write-enable demux and read mux; read is registered.
  always @(posedge clk) begin
    if (ram_we) mem[{ram_sel, ram_addr}] <= ram_din;
    ram_dout <= mem[{ram_sel, ram_addr}];
  end

  task automatic test_reset();
    reset = 1'b1;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = 8'h00; a_if.wdata = 8'h00;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = 8'h00; b_if.wdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({ram_sel, ram_addr, ram_din, ram_we} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_ram_side: got sel=%h addr=%h din=%h we=%b required all 0", ram_sel, ram_addr, ram_din, ram_we);
    end
    vectors++;
    if ({a_if.ack, b_if.ack, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got a_ack=%b b_ack=%b busy=%b required 0", a_if.ack, b_if.ack, busy);
    end
    vectors++;
    if ({a_if.rdata, b_if.rdata} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got a=%h b=%h required 0", a_if.rdata, b_if.rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_a();
    a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 8'h47; a_if.wdata = 8'hA5;
    @(negedge clk);
    vectors++;
    if ({ram_we, ram_sel, ram_addr, ram_din, busy, a_if.ack} !== {1'b1, 2'd1, 6'h07, 8'hA5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL write_a_access: got we=%b sel=%0d addr=%h din=%h busy=%b ack=%b required 1 1 07 a5 1 0",
               ram_we, ram_sel, ram_addr, ram_din, busy, a_if.ack);
    end
    @(negedge clk);
    vectors++;
    if ({ram_we, busy, a_if.ack, ram_sel} !== {1'b0, 1'b1, 1'b0, 2'd1}) begin
      miscompares++;
      $display("FAIL write_a_complete: got we=%b busy=%b ack=%b sel=%0d required 0 1 0 1", ram_we, busy, a_if.ack, ram_sel);
    end
    @(negedge clk);
    vectors++;
    if ({a_if.ack, b_if.ack, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL write_a_ack: got a_ack=%b b_ack=%b busy=%b required 1 0 0", a_if.ack, b_if.ack, busy);
    end
    a_if.req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({a_if.ack, busy, ram_we} !== 3'b000) begin
      miscompares++;
      $display("FAIL write_a_after: got ack=%b busy=%b we=%b required 0 0 0", a_if.ack, busy, ram_we);
    end
  endtask

  task automatic test_read_a();
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 8'h47; a_if.wdata = 8'h00;
    @(negedge clk);
    vectors++;
    if ({ram_we, busy, ram_sel, ram_addr} !== {1'b0, 1'b1, 2'd1, 6'h07}) begin
      miscompares++;
      $display("FAIL read_a_access: got we=%b busy=%b sel=%0d addr=%h required 0 1 1 07", ram_we, busy, ram_sel, ram_addr);
    end
    @(negedge clk);
    vectors++;
    if ({ram_we, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL read_a_complete: got we=%b busy=%b required 0 1", ram_we, busy);
    end
    @(negedge clk);
    vectors++;
    if ({a_if.ack, a_if.rdata, b_if.rdata} !== {1'b1, 8'hA5, 8'h00}) begin
      miscompares++;
      $display("FAIL read_a_ack: got ack=%b a_rdata=%h b_rdata=%h required 1 a5 00", a_if.ack, a_if.rdata, b_if.rdata);
    end
    // req still held through the ack cycle: must not be regranted
    @(negedge clk);
    vectors++;
    if ({busy, a_if.ack, a_if.rdata} !== {1'b0, 1'b0, 8'hA5}) begin
      miscompares++;
      $display("FAIL read_a_no_regrant: got busy=%b ack=%b rdata=%h required 0 0 a5", busy, a_if.ack, a_if.rdata);
    end
    a_if.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 8'h00; a_if.wdata = 8'h11;
    b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 8'hFF; b_if.wdata = 8'h22;
    for (int i = 1; i <= 12; i++) begin
      int  g;
      logic exp_we, exp_a_ack, exp_b_ack;
      @(negedge clk);
      g = (i - 1) / 3;
      exp_we    = (i % 3 == 1);
      exp_a_ack = (i % 3 == 0) && (g % 2 == 0);
      exp_b_ack = (i % 3 == 0) && (g % 2 == 1);
      vectors++;
      if ({ram_we, a_if.ack, b_if.ack} !== {exp_we, exp_a_ack, exp_b_ack}) begin
        miscompares++;
        $display("FAIL contention_cycle%0d: got we=%b a_ack=%b b_ack=%b required %b %b %b",
                 i, ram_we, a_if.ack, b_if.ack, exp_we, exp_a_ack, exp_b_ack);
      end
      if (exp_we) begin
        vectors++;
        if (g % 2 == 0) begin
          if ({ram_sel, ram_addr, ram_din} !== {2'd0, 6'h00, 8'h11}) begin
            miscompares++;
            $display("FAIL contention_a%0d: got sel=%0d addr=%h din=%h required 0 00 11", g, ram_sel, ram_addr, ram_din);
          end
        end else begin
          if ({ram_sel, ram_addr, ram_din} !== {2'd3, 6'h3F, 8'h22}) begin
            miscompares++;
            $display("FAIL contention_b%0d: got sel=%0d addr=%h din=%h required 3 3f 22", g, ram_sel, ram_addr, ram_din);
          end
        end
      end
    end
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, mem[0], mem[255]} !== {1'b0, 8'h11, 8'h22}) begin
      miscompares++;
      $display("FAIL contention_end: got busy=%b mem00=%h memff=%h required 0 11 22", busy, mem[0], mem[255]);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] addrs [6] = '{8'h3F, 8'h40, 8'h7F, 8'h80, 8'hBF, 8'hC0};
    logic [1:0] sels  [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [5:0] locs  [6] = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00};
    for (int k = 0; k < 6; k++) begin
      a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = addrs[k]; a_if.wdata = addrs[k] ^ 8'hFF;
      @(negedge clk);
      vectors++;
      if ({ram_we, ram_sel, ram_addr, ram_din} !== {1'b1, sels[k], locs[k], addrs[k] ^ 8'hFF}) begin
        miscompares++;
        $display("FAIL boundary_%h: got we=%b sel=%0d local=%h din=%h required 1 %0d %h %h",
                 addrs[k], ram_we, ram_sel, ram_addr, ram_din, sels[k], locs[k], addrs[k] ^ 8'hFF);
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (a_if.ack !== 1'b1) begin
        miscompares++;
        $display("FAIL boundary_ack_%h: got %b required 1", addrs[k], a_if.ack);
      end
      a_if.req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_withdrawal();
    int n_ack = 0;
    int n_we = 0;
    b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 8'h90; b_if.wdata = 8'h5A;
    @(negedge clk);
    vectors++;
    if ({ram_we, ram_sel, ram_addr, ram_din} !== {1'b1, 2'd2, 6'h10, 8'h5A}) begin
      miscompares++;
      $display("FAIL withdraw_access: got we=%b sel=%0d addr=%h din=%h required 1 2 10 5a", ram_we, ram_sel, ram_addr, ram_din);
    end
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = 8'h00; b_if.wdata = 8'hEE;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b_if.ack) n_ack++;
      if (ram_we) n_we++;
    end
    vectors++;
    if ({n_ack, n_we} !== {32'd1, 32'd0}) begin
      miscompares++;
      $display("FAIL withdraw_ack_count: got acks=%0d extra_writes=%0d required 1 0", n_ack, n_we);
    end
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 8'h90;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({b_if.ack, b_if.rdata, a_if.rdata} !== {1'b1, 8'h5A, 8'h00}) begin
      miscompares++;
      $display("FAIL withdraw_readback: got ack=%b b_rdata=%h a_rdata=%h required 1 5a 00", b_if.ack, b_if.rdata, a_if.rdata);
    end
    b_if.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 8'h47;
    @(negedge clk);
    vectors++;
    if ({busy, ram_sel} !== {1'b1, 2'd1}) begin
      miscompares++;
      $display("FAIL reset_mid_access: got busy=%b sel=%0d required 1 1", busy, ram_sel);
    end
    reset = 1'b1;
    a_if.req = 1'b0;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 8'h00;
    @(negedge clk);
    vectors++;
    if ({a_if.ack, b_if.ack, busy, ram_we, ram_sel, ram_addr, ram_din, a_if.rdata, b_if.rdata} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got a_ack=%b b_ack=%b busy=%b we=%b sel=%0d addr=%h din=%h ard=%h brd=%h required all 0",
               a_if.ack, b_if.ack, busy, ram_we, ram_sel, ram_addr, ram_din, a_if.rdata, b_if.rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, ram_we, ram_sel, ram_addr, a_if.ack} !== {1'b1, 1'b0, 2'd0, 6'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_b_grant: got busy=%b we=%b sel=%0d addr=%h a_ack=%b required 1 0 0 00 0",
               busy, ram_we, ram_sel, ram_addr, a_if.ack);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({b_if.ack, b_if.rdata, a_if.ack, a_if.rdata} !== {1'b1, 8'h11, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_mid_b_done: got b_ack=%b b_rdata=%h a_ack=%b a_rdata=%h required 1 11 0 00",
               b_if.ack, b_if.rdata, a_if.ack, a_if.rdata);
    end
    b_if.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_a();
    test_contention();
    test_boundary();
    test_withdrawal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
